// File: rtl/booth_div_seq_pkg.sv
// Shared definitions for the sequential signed divider: default widths,
// controller state encoding and the iteration counter width helper.
package booth_div_seq_pkg;

    localparam int DBITS_DEF = 20;
    localparam int NBITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

    // Width of a counter that runs bits-1 down to 0.
    function automatic int cnt_width(input int bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

endpackage

// File: rtl/booth_div_seq_abs_sign.sv
// Two's-complement magnitude/sign split; the magnitude is one bit wider so
// the most negative input converts exactly.
module booth_div_seq_abs_sign #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_val,
    output logic [W:0]   o_mag,
    output logic         o_sign
);

    logic [W:0] w_ext;

    assign w_ext  = {i_val[W-1], i_val};
    assign o_sign = i_val[W-1];
    assign o_mag  = o_sign ? (~w_ext + 1'b1) : w_ext;

endmodule

// File: rtl/booth_div_seq.sv
// Sequential signed restoring divider: DBITS-bit dividend / NBITS-bit divisor,
// quotient truncated toward zero, remainder carrying the dividend's sign.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; operands, magnitudes and signs latched on start
//   CALC  | one unsigned quotient bit per cycle, MSB first, DBITS cycles
//   FIX   | apply signs, flag overflow, pulse done
//   ZERO  | divisor was zero: quo all ones, rem = low dividend bits, dbz
module booth_div_seq
    import booth_div_seq_pkg::*;
#(
    parameter int DBITS = DBITS_DEF,
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DBITS-1:0] dvd,
    input  logic [NBITS-1:0] dvs,
    output logic [DBITS-1:0] quo,
    output logic [NBITS-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = cnt_width(DBITS);

    state_t             r_state;
    state_t             w_next;

    logic [DBITS:0]     w_dvd_mag;
    logic               w_dvd_sign;
    logic [NBITS:0]     w_dvs_mag;
    logic               w_dvs_sign;
    logic               w_dvs_zero;

    logic [NBITS-1:0]   r_dvd_lo;
    logic [DBITS-1:0]   r_q;
    logic [NBITS:0]     r_pr;
    logic [NBITS:0]     r_dvs_mag;
    logic               r_sdvd;
    logic               r_sdvs;
    logic [CW-1:0]      r_cnt;

    logic [NBITS+1:0]   w_trial;
    logic               w_ge;
    logic [NBITS:0]     w_diff;

    booth_div_seq_abs_sign #(.W(DBITS)) u_abs_dvd (
        .i_val  (dvd),
        .o_mag  (w_dvd_mag),
        .o_sign (w_dvd_sign)
    );

    booth_div_seq_abs_sign #(.W(NBITS)) u_abs_dvs (
        .i_val  (dvs),
        .o_mag  (w_dvs_mag),
        .o_sign (w_dvs_sign)
    );

    assign w_dvs_zero = (dvs == '0);

    // r_q shifts dividend bits out of its MSB while quotient bits enter its LSB.
    assign w_trial = {r_pr, r_q[DBITS-1]};
    assign w_ge    = (w_trial >= {1'b0, r_dvs_mag});
    assign w_diff  = w_trial[NBITS:0] - r_dvs_mag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = w_dvs_zero ? ZERO : CALC;
            CALC:    if (r_cnt == '0) w_next = FIX;
            FIX:     w_next = IDLE;
            ZERO:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo       <= '0;
            rem       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
            r_dvd_lo  <= '0;
            r_q       <= '0;
            r_pr      <= '0;
            r_dvs_mag <= '0;
            r_sdvd    <= 1'b0;
            r_sdvs    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        dbz       <= 1'b0;
                        ovf       <= 1'b0;
                        r_dvd_lo  <= dvd[NBITS-1:0];
                        r_q       <= w_dvd_mag[DBITS-1:0];
                        // Top magnitude bit seeds the partial remainder.
                        r_pr      <= {{NBITS{1'b0}}, w_dvd_mag[DBITS]};
                        r_dvs_mag <= w_dvs_mag;
                        r_sdvd    <= w_dvd_sign;
                        r_sdvs    <= w_dvs_sign;
                        r_cnt     <= CW'(DBITS - 1);
                    end
                end
                CALC: begin
                    r_q   <= {r_q[DBITS-2:0], w_ge};
                    r_pr  <= w_ge ? w_diff : w_trial[NBITS:0];
                    r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    quo  <= (r_sdvd ^ r_sdvs) ? -r_q : r_q;
                    rem  <= r_sdvd ? -r_pr[NBITS-1:0] : r_pr[NBITS-1:0];
                    // A positive quotient with its MSB set can only be min/-1.
                    ovf  <= ~(r_sdvd ^ r_sdvs) & r_q[DBITS-1];
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                ZERO: begin
                    quo  <= '1;
                    rem  <= r_dvd_lo;
                    dbz  <= 1'b1;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
